// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-PC generator: next-PC op encodings and default vectors.
package pc_pkg;

   localparam int XLEN_DEF = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
   localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;

   typedef enum logic [2:0] {
      NPC_SEQ = 3'b000,
      NPC_BR  = 3'b001,
      NPC_J   = 3'b010,
      NPC_JR  = 3'b011
   } npc_op_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational D-stage redirect target: branch, jump and register-jump addresses.
module pc_target_calc
   import pc_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [2:0]      npc_op,
   input  logic [XLEN-1:0] d_pc,
   input  logic [15:0]     imm_off,
   input  logic [25:0]     imm_j,
   input  logic [XLEN-1:0] jr_target,
   output logic            redir,
   output logic [XLEN-1:0] target
);

   logic [XLEN-1:0] br_off;

   assign br_off = {{(XLEN-18){imm_off[15]}}, imm_off, 2'b00};

   always_comb begin
      redir  = 1'b0;
      target = '0;
      case (npc_op)
         NPC_BR: begin
            redir  = 1'b1;
            target = d_pc + XLEN'(4) + br_off;
         end
         NPC_J: begin
            redir  = 1'b1;
            target = {d_pc[XLEN-1:28], imm_j, 2'b00};
         end
         NPC_JR: begin
            redir  = 1'b1;
            target = jr_target;
         end
         default: begin
            redir  = 1'b0;
            target = '0;
         end
      endcase
   end

endmodule

// File: rtl/pc_gen.sv
// Fetch-PC register with exception/eret/redirect priority and a one-entry pending redirect buffer.
// Optional fetch address-error check enabled by defining ADEL_CHK_EN.
module pc_gen
   import pc_pkg::*;
#(
   parameter int          XLEN     = XLEN_DEF,
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF,
   parameter logic [31:0] IM_BASE  = 32'h0000_3000,
   parameter logic [31:0] IM_LIMIT = 32'h0000_6FFC
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall_i,
   input  logic            imem_ready_i,
   input  logic [2:0]      npc_op_i,
   input  logic [XLEN-1:0] d_pc_i,
   input  logic [15:0]     imm_off_i,
   input  logic [25:0]     imm_j_i,
   input  logic [XLEN-1:0] jr_target_i,
   input  logic            exc_req_i,
   input  logic            eret_i,
   input  logic [XLEN-1:0] epc_i,
   output logic [XLEN-1:0] f_pc_o,
   output logic            f_valid_o,
   output logic            f_exc_o,
   output logic            pend_o
);

   if (IM_BASE > IM_LIMIT) begin : g_bad_range
      $error("pc_gen: IM_BASE is above IM_LIMIT");
   end

   logic            advance;
   logic            redir;
   logic [XLEN-1:0] redir_pc;
   logic [XLEN-1:0] evt_pc;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pend_pc_q, pend_pc_d;
   logic            pend_q, pend_d;

   assign advance = imem_ready_i & ~stall_i;

   pc_target_calc #(.XLEN(XLEN)) u_target (
      .npc_op    (npc_op_i),
      .d_pc      (d_pc_i),
      .imm_off   (imm_off_i),
      .imm_j     (imm_j_i),
      .jr_target (jr_target_i),
      .redir     (redir),
      .target    (redir_pc)
   );

   // M-stage events bypass the hazard stall; only a busy imem forces them into the buffer.
   always_comb begin
      pc_d      = pc_q;
      pend_d    = pend_q;
      pend_pc_d = pend_pc_q;
      evt_pc    = exc_req_i ? XLEN'(EXC_VEC) : epc_i;
      if (exc_req_i | eret_i) begin
         if (imem_ready_i) begin
            pc_d   = evt_pc;
            pend_d = 1'b0;
         end else begin
            pend_d    = 1'b1;
            pend_pc_d = evt_pc;
         end
      end else if (advance) begin
         pend_d = 1'b0;
         if (pend_q) begin
            pc_d = pend_pc_q;
         end else if (redir) begin
            pc_d = redir_pc;
         end else begin
            pc_d = pc_q + XLEN'(4);
         end
      end else if (!stall_i && redir && !pend_q) begin
         pend_d    = 1'b1;
         pend_pc_d = redir_pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= XLEN'(RESET_PC);
         pend_q    <= 1'b0;
         pend_pc_q <= '0;
      end else begin
         pc_q      <= pc_d;
         pend_q    <= pend_d;
         pend_pc_q <= pend_pc_d;
      end
   end

   assign f_pc_o = pc_q;
   assign pend_o = pend_q;

`ifdef ADEL_CHK_EN
   logic bad_addr;
   assign bad_addr  = (pc_q[1:0] != 2'b00) || (pc_q < XLEN'(IM_BASE)) || (pc_q > XLEN'(IM_LIMIT));
   assign f_exc_o   = bad_addr;
   assign f_valid_o = ~bad_addr;
`else
   assign f_exc_o   = 1'b0;
   assign f_valid_o = 1'b1;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic against a reference model.
module tb_pc_gen;
   import pc_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_3000;
   localparam logic [31:0] EXC_PC = 32'h0000_4180;
   localparam logic [31:0] IM_LO  = 32'h0000_3000;
   localparam logic [31:0] IM_HI  = 32'h0000_6FFC;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        ready = 1'b1;
   logic [2:0]  op = 3'b000;
   logic [31:0] d_pc = '0;
   logic [15:0] imm_off = '0;
   logic [25:0] imm_j = '0;
   logic [31:0] jr_target = '0;
   logic        exc_req = 1'b0;
   logic        eret = 1'b0;
   logic [31:0] epc = '0;
   logic [31:0] f_pc;
   logic        f_valid, f_exc, pend;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_pc;
   logic        m_pend;
   logic [31:0] m_pend_pc;

   always #5 clk = ~clk;

   pc_gen dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall_i      (stall),
      .imem_ready_i (ready),
      .npc_op_i     (op),
      .d_pc_i       (d_pc),
      .imm_off_i    (imm_off),
      .imm_j_i      (imm_j),
      .jr_target_i  (jr_target),
      .exc_req_i    (exc_req),
      .eret_i       (eret),
      .epc_i        (epc),
      .f_pc_o       (f_pc),
      .f_valid_o    (f_valid),
      .f_exc_o      (f_exc),
      .pend_o       (pend)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic legal_fetch(input logic [31:0] a);
`ifdef ADEL_CHK_EN
      return (a % 4 == 0) && (a >= IM_LO) && (a <= IM_HI);
`else
      return 1'b1;
`endif
   endfunction

   task automatic check_outs(input string tag);
      check({tag, ".pc"},    f_pc, m_pc);
      check({tag, ".pend"},  {31'b0, pend}, {31'b0, m_pend});
      check({tag, ".valid"}, {31'b0, f_valid}, {31'b0, legal_fetch(m_pc)});
      check({tag, ".exc"},   {31'b0, f_exc}, {31'b0, ~legal_fetch(m_pc)});
   endtask

   // Reference: decide where the fetch PC should be after this edge from the stated rules.
   task automatic model_edge();
      logic        has_tgt;
      logic [31:0] tgt;
      logic [31:0] soff;
      soff    = {{16{imm_off[15]}}, imm_off};
      has_tgt = 1'b1;
      case (op)
         3'd1:    tgt = d_pc + 32'd4 + soff * 32'd4;
         3'd2:    tgt = (d_pc & 32'hF000_0000) + ({6'b0, imm_j} * 32'd4);
         3'd3:    tgt = jr_target;
         default: begin tgt = '0; has_tgt = 1'b0; end
      endcase
      if (exc_req || eret) begin
         if (ready) begin
            m_pc   = exc_req ? EXC_PC : epc;
            m_pend = 1'b0;
         end else begin
            m_pend_pc = exc_req ? EXC_PC : epc;
            m_pend    = 1'b1;
         end
      end else if (ready && !stall) begin
         m_pc   = m_pend ? m_pend_pc : (has_tgt ? tgt : m_pc + 32'd4);
         m_pend = 1'b0;
      end else if (!stall && has_tgt && !m_pend) begin
         m_pend_pc = tgt;
         m_pend    = 1'b1;
      end
   endtask

   task automatic step(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_outs(tag);
   endtask

   task automatic idle_inputs();
      stall = 1'b0; ready = 1'b1; op = 3'b000; exc_req = 1'b0; eret = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      m_pc = RST_PC; m_pend = 1'b0; m_pend_pc = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check_outs("reset");
      check("reset.pc_const", f_pc, 32'h0000_3000);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] seq_exp [3];
      seq_exp[0] = 32'h3004; seq_exp[1] = 32'h3008; seq_exp[2] = 32'h300C;

      do_reset();
      for (int i = 0; i < 3; i++) begin
         step("seq");
         check("seq_const", f_pc, seq_exp[i]);
      end

      do_reset();
      step("br_pre"); step("br_pre");
      op = 3'b001; d_pc = 32'h3004; imm_off = 16'h0003;
      step("br");
      check("br_const", f_pc, 32'h3014);
      check("br_nopend", {31'b0, pend}, 32'd0);

      do_reset();
      op = 3'b000;
      step("pb_pre"); step("pb_pre");
      op = 3'b001; ready = 1'b0;
      step("pb_hold"); step("pb_hold");
      check("pb_hold_pc", f_pc, 32'h3008);
      check("pb_hold_pend", {31'b0, pend}, 32'd1);
      ready = 1'b1;
      step("pb_take");
      check("pb_take_pc", f_pc, 32'h3014);
      check("pb_take_pend", {31'b0, pend}, 32'd0);

      stall = 1'b1; op = 3'b011; jr_target = 32'h3100;
      step("stall_jr");
      check("stall_jr_pc", f_pc, 32'h3014);
      exc_req = 1'b1;
      step("stall_exc");
      check("stall_exc_pc", f_pc, 32'h4180);
      exc_req = 1'b0; stall = 1'b0; op = 3'b000;

      exc_req = 1'b1; eret = 1'b1; epc = 32'h3020;
      step("exc_eret");
      check("exc_eret_pc", f_pc, 32'h4180);
      exc_req = 1'b0; eret = 1'b0;
      step("handler");
      eret = 1'b1;
      step("eret");
      check("eret_pc", f_pc, 32'h3020);
      eret = 1'b0;

`ifdef ADEL_CHK_EN
      op = 3'b011; jr_target = 32'h3002;
      step("adel_mis");
      check("adel_mis_pc", f_pc, 32'h3002);
      check("adel_mis_exc", {31'b0, f_exc}, 32'd1);
      check("adel_mis_valid", {31'b0, f_valid}, 32'd0);
      jr_target = 32'h7000;
      step("adel_hi");
      check("adel_hi_exc", {31'b0, f_exc}, 32'd1);
      op = 3'b000;
`endif

      for (int i = 0; i < 3000; i++) begin
         stall     = ($urandom_range(0, 3) == 0);
         ready     = ($urandom_range(0, 3) != 0);
         op        = 3'($urandom_range(0, 7));
         d_pc      = {$urandom} & 32'hFFFF_FFFC;
         imm_off   = 16'($urandom);
         imm_j     = 26'($urandom);
         jr_target = ($urandom_range(0, 1) == 0) ? ({$urandom} & 32'h0000_7FFF) : $urandom;
         exc_req   = ($urandom_range(0, 15) == 0);
         eret      = ($urandom_range(0, 15) == 0);
         epc       = $urandom;
         if (i == 1500) begin
            #1;
            rst_n = 1'b0;
            #1;
            m_pc = RST_PC; m_pend = 1'b0; m_pend_pc = '0;
            check_outs("async_rst");
            @(negedge clk);
            rst_n = 1'b1;
         end else begin
            step("rand");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
